// File: rtl/x86_regs_pkg.sv
// Shared register-file definitions: x86 register indices, widths and the write-back entry type.
package x86_regs_pkg;

    localparam int unsigned NUM_REGISTERS = 16;
    localparam int unsigned REG_IDX_W     = 5;
    localparam int unsigned WORD_W        = 32;

    localparam logic [REG_IDX_W-1:0] EAX       = 5'd0;
    localparam logic [REG_IDX_W-1:0] ECX       = 5'd1;
    localparam logic [REG_IDX_W-1:0] EDX       = 5'd2;
    localparam logic [REG_IDX_W-1:0] EBX       = 5'd3;
    localparam logic [REG_IDX_W-1:0] ESP       = 5'd4;
    localparam logic [REG_IDX_W-1:0] EBP       = 5'd5;
    localparam logic [REG_IDX_W-1:0] ESI       = 5'd6;
    localparam logic [REG_IDX_W-1:0] EDI       = 5'd7;
    localparam logic [REG_IDX_W-1:0] ES        = 5'd8;
    localparam logic [REG_IDX_W-1:0] CS        = 5'd9;
    localparam logic [REG_IDX_W-1:0] SS        = 5'd10;
    localparam logic [REG_IDX_W-1:0] DS        = 5'd11;
    localparam logic [REG_IDX_W-1:0] FS        = 5'd12;
    localparam logic [REG_IDX_W-1:0] GS        = 5'd13;
    localparam logic [REG_IDX_W-1:0] EFLAGS    = 5'd14;
    localparam logic [REG_IDX_W-1:0] INSTR_PTR = 5'd15;

    typedef struct packed {
        logic [REG_IDX_W-1:0] reg_idx;
        logic [WORD_W-1:0]    val;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority search for one bypass index; only built when WB_BYPASS_EN is defined.
// Entries are ordered oldest (index 0) to youngest; the youngest valid match wins.
`ifdef WB_BYPASS_EN
module wb_fwd_match
    import x86_regs_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  wb_entry_t [N-1:0]     i_entries,
    input  logic [N-1:0]          i_valid,
    input  logic [REG_IDX_W-1:0]  i_reg,
    output logic                  o_hit,
    output logic [WORD_W-1:0]     o_val
);

    always_comb begin
        o_hit = 1'b0;
        o_val = '0;
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && (i_entries[i].reg_idx == i_reg)) begin
                o_hit = 1'b1;
                o_val = i_entries[i].val;
            end
        end
    end

endmodule
`endif

// File: rtl/writeback_queue.sv
// Write-back FIFO feeding the single register_file write port, one drain per clock.
// Optional read-after-write bypass of pending writes when WB_BYPASS_EN is defined.
module writeback_queue
    import x86_regs_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wb_valid,
    output logic                      o_wb_ready,
    input  logic [ADDR_W-1:0]         i_wb_reg,
    input  logic [DATA_W-1:0]         i_wb_val,
    input  logic                      i_hold,
    output logic                      o_rf_write,
    output logic [ADDR_W-1:0]         o_rf_ctrl_write,
    output logic [DATA_W-1:0]         o_rf_write_val,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty,
    output logic                      o_full,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0]         i_fwd_reg1,
    input  logic [ADDR_W-1:0]         i_fwd_reg2,
    output logic                      o_fwd_hit1,
    output logic                      o_fwd_hit2,
    output logic [DATA_W-1:0]         o_fwd_val1,
    output logic [DATA_W-1:0]         o_fwd_val2,
`endif
    output logic                      o_bad_reg
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_rf_write;
    wb_entry_t          r_out;
    logic               r_bad_reg;

    logic w_accept;
    logic w_bad_idx;
    logic w_store;
    logic w_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_wb_ready = !o_full;

    assign w_accept  = i_wb_valid && o_wb_ready;
    assign w_bad_idx = (32'(i_wb_reg) >= NUM_REGISTERS);
    // Out-of-range indices are consumed from execute but never reach the register file.
    assign w_store   = w_accept && !w_bad_idx;
    assign w_pop     = !o_empty && !i_hold;

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_tail] <= '{reg_idx: REG_IDX_W'(i_wb_reg), val: WORD_W'(i_wb_val)};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rf_write <= 1'b0;
            r_out      <= '0;
            r_bad_reg  <= 1'b0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_out  <= r_mem[r_head];
                r_head <= r_head + 1'b1;
            end
            r_rf_write <= w_pop;
            r_bad_reg  <= w_accept && w_bad_idx;
            r_count    <= r_count + CNT_W'(w_store) - CNT_W'(w_pop);
        end
    end

    assign o_rf_write      = r_rf_write;
    assign o_rf_ctrl_write = ADDR_W'(r_out.reg_idx);
    assign o_rf_write_val  = DATA_W'(r_out.val);
    assign o_count         = r_count;
    assign o_bad_reg       = r_bad_reg;

`ifdef WB_BYPASS_EN
    localparam int unsigned N_SRCH = DEPTH + 1;

    wb_entry_t [N_SRCH-1:0] w_srch;
    logic [N_SRCH-1:0]      w_srch_vld;
    logic [WORD_W-1:0]      w_fwd_val1;
    logic [WORD_W-1:0]      w_fwd_val2;

    // Slot 0 is the output register (oldest); queue entries follow in age order from head.
    always_comb begin
        w_srch[0]     = r_out;
        w_srch_vld[0] = r_rf_write;
        for (int i = 0; i < DEPTH; i++) begin
            w_srch[i+1]     = r_mem[r_head + PTR_W'(i)];
            w_srch_vld[i+1] = (CNT_W'(i) < r_count);
        end
    end

    wb_fwd_match #(
        .N (N_SRCH)
    ) u_fwd_match1 (
        .i_entries (w_srch),
        .i_valid   (w_srch_vld),
        .i_reg     (REG_IDX_W'(i_fwd_reg1)),
        .o_hit     (o_fwd_hit1),
        .o_val     (w_fwd_val1)
    );

    wb_fwd_match #(
        .N (N_SRCH)
    ) u_fwd_match2 (
        .i_entries (w_srch),
        .i_valid   (w_srch_vld),
        .i_reg     (REG_IDX_W'(i_fwd_reg2)),
        .o_hit     (o_fwd_hit2),
        .o_val     (w_fwd_val2)
    );

    assign o_fwd_val1 = DATA_W'(w_fwd_val1);
    assign o_fwd_val2 = DATA_W'(w_fwd_val2);
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: vector table plus hand sequences for reset and bypass.
module tb_writeback_queue;
    import x86_regs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic        hold;
    logic        rf_write;
    logic [4:0]  rf_ctrl;
    logic [31:0] rf_val;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        bad_reg;
`ifdef WB_BYPASS_EN
    logic [4:0]  fwd_reg1;
    logic [4:0]  fwd_reg2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_val1;
    logic [31:0] fwd_val2;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    writeback_queue #(
        .DEPTH  (4),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wb_valid      (wb_valid),
        .o_wb_ready      (wb_ready),
        .i_wb_reg        (wb_reg),
        .i_wb_val        (wb_val),
        .i_hold          (hold),
        .o_rf_write      (rf_write),
        .o_rf_ctrl_write (rf_ctrl),
        .o_rf_write_val  (rf_val),
        .o_count         (count),
        .o_empty         (empty),
        .o_full          (full),
`ifdef WB_BYPASS_EN
        .i_fwd_reg1      (fwd_reg1),
        .i_fwd_reg2      (fwd_reg2),
        .o_fwd_hit1      (fwd_hit1),
        .o_fwd_hit2      (fwd_hit2),
        .o_fwd_val1      (fwd_val1),
        .o_fwd_val2      (fwd_val2),
`endif
        .o_bad_reg       (bad_reg)
    );

    // Register file model: commits on the falling edge, like register_file.
    logic [31:0] rf_model [32] = '{default: 32'hDEAD_BEEF};
    always @(negedge clk) begin
        if (rf_write) rf_model[rf_ctrl] <= rf_val;
    end

    typedef struct {
        logic        valid;
        logic [4:0]  wreg;
        logic [31:0] wval;
        logic        hold;
        logic        e_wr;
        logic [4:0]  e_ctrl;
        logic [31:0] e_val;
        logic [2:0]  e_cnt;
        logic        e_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic vl, logic [4:0] r, logic [31:0] d, logic h, logic ew,
                                logic [4:0] ec, logic [31:0] ed, logic [2:0] cnt, logic bad);
        vec_t v;
        v.valid = vl; v.wreg = r; v.wval = d; v.hold = h;
        v.e_wr = ew; v.e_ctrl = ec; v.e_val = ed; v.e_cnt = cnt; v.e_bad = bad;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        wb_valid = v.valid;
        wb_reg   = v.wreg;
        wb_val   = v.wval;
        hold     = v.hold;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d rf_write", idx), 32'(rf_write), 32'(v.e_wr));
        if (v.e_wr) begin
            chk($sformatf("v%0d rf_ctrl", idx), 32'(rf_ctrl), 32'(v.e_ctrl));
            chk($sformatf("v%0d rf_val", idx), rf_val, v.e_val);
        end
        chk($sformatf("v%0d count", idx), 32'(count), 32'(v.e_cnt));
        chk($sformatf("v%0d empty", idx), 32'(empty), 32'(v.e_cnt == 3'd0));
        chk($sformatf("v%0d full", idx), 32'(full), 32'(v.e_cnt == 3'd4));
        chk($sformatf("v%0d ready", idx), 32'(wb_ready), 32'(v.e_cnt != 3'd4));
        chk($sformatf("v%0d bad_reg", idx), 32'(bad_reg), 32'(v.e_bad));
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        wb_reg   = '0;
        wb_val   = '0;
        hold     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
`ifdef WB_BYPASS_EN
        fwd_reg1 = EAX;
        fwd_reg2 = EAX;
`endif
        #2;
        chk("reset rf_write", 32'(rf_write), 0);
        chk("reset rf_ctrl", 32'(rf_ctrl), 0);
        chk("reset rf_val", rf_val, 0);
        chk("reset count", 32'(count), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset full", 32'(full), 0);
        chk("reset ready", 32'(wb_ready), 1);
        chk("reset bad_reg", 32'(bad_reg), 0);
`ifdef WB_BYPASS_EN
        chk("reset fwd_hit1", 32'(fwd_hit1), 0);
        chk("reset fwd_val1", fwd_val1, 0);
`endif
        #10;
        rst = 1'b0;

        // Single push of EAX, then drain
        vecs.push_back(mk(1, EAX, 32'h11, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, EAX, 32'h11, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill under hold, offer a fifth, then drain in order
        vecs.push_back(mk(1, EDX, 32'hA0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, EBX, 32'hA1, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, ESP, 32'hA2, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, EBP, 32'hA3, 1, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, ESI, 32'hA4, 1, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, ESI, 32'hA4, 0, 1, EDX, 32'hA0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, EBX, 32'hA1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, ESP, 32'hA2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, EBP, 32'hA3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Same-register writes back to back
        vecs.push_back(mk(1, ECX, 32'h1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, ECX, 32'h2, 0, 1, ECX, 32'h1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, ECX, 32'h2, 0, 0));
        // Out-of-range index
        vecs.push_back(mk(1, 5'd20, 32'h99, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Build count 2, then 10 cycles of push+pop
        vecs.push_back(mk(1, EDI, 32'hB0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, ES, 32'hB1, 1, 0, 0, 0, 2, 0));
        for (int i = 0; i < 10; i++) begin
            logic [4:0]  er;
            logic [31:0] ev;
            if (i == 0) begin
                er = EDI; ev = 32'hB0;
            end else if (i == 1) begin
                er = ES; ev = 32'hB1;
            end else begin
                er = 5'(10 + ((i - 2) % 6)); ev = 32'hC0 + 32'(i - 2);
            end
            vecs.push_back(mk(1, 5'(10 + (i % 6)), 32'hC0 + 32'(i), 0, 1, er, ev, 2, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 1, FS, 32'hC8, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, GS, 32'hC9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
        @(negedge clk);
        #1;
        chk("rf EAX", rf_model[EAX], 32'h11);
        chk("rf ECX", rf_model[ECX], 32'h2);
        chk("rf EDX", rf_model[EDX], 32'hA0);
        chk("rf EBP", rf_model[EBP], 32'hA3);
        chk("rf ESI held offer", rf_model[ESI], 32'hDEAD_BEEF);
        chk("rf ES", rf_model[ES], 32'hB1);
        chk("rf SS wrap", rf_model[SS], 32'hC6);
        chk("rf GS wrap", rf_model[GS], 32'hC9);
        chk("rf EFLAGS wrap", rf_model[EFLAGS], 32'hC4);
        chk("rf idx20", rf_model[20], 32'hDEAD_BEEF);

`ifdef WB_BYPASS_EN
        // Bypass: two pending ECX writes, youngest wins, output register included
        idle_inputs();
        hold = 1'b1;
        wb_valid = 1'b1; wb_reg = ECX; wb_val = 32'h5;
        @(posedge clk); #1;
        wb_reg = ECX; wb_val = 32'h7;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        fwd_reg1 = ECX; fwd_reg2 = EDX;
        #1;
        chk("fwd both queued hit1", 32'(fwd_hit1), 1);
        chk("fwd both queued val1", fwd_val1, 32'h7);
        chk("fwd miss hit2", 32'(fwd_hit2), 0);
        hold = 1'b0;
        @(posedge clk); #1;
        chk("fwd out+queue hit1", 32'(fwd_hit1), 1);
        chk("fwd out+queue val1", fwd_val1, 32'h7);
        fwd_reg2 = ECX;
        @(posedge clk); #1;
        chk("fwd out only hit2", 32'(fwd_hit2), 1);
        chk("fwd out only val2", fwd_val2, 32'h7);
        @(posedge clk); #1;
        chk("fwd drained hit1", 32'(fwd_hit1), 0);
        chk("rf ECX bypass", rf_model[ECX], 32'h7);
`endif

        // Reset with one write in the output register and three pending
        idle_inputs();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_reg = ESI; wb_val = 32'hD0 + 32'(i);
            @(posedge clk); #1;
        end
        wb_valid = 1'b0;
        hold = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset rf_write", 32'(rf_write), 1);
        chk("pre-reset count", 32'(count), 3);
        rst = 1'b1;
        #1;
        chk("async reset rf_write", 32'(rf_write), 0);
        chk("async reset empty", 32'(empty), 1);
        chk("async reset count", 32'(count), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset rf_write %0d", i), 32'(rf_write), 0);
            chk($sformatf("post-reset empty %0d", i), 32'(empty), 1);
        end
        chk("rf ESI after reset", rf_model[ESI], 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
